// File: rtl/tone_envelope_if.sv
// Signal bundle between the note-select/tone_gen side and the ADSR tone shaper.
// Inputs are sampled on every rising clk and outputs update on every clk; there is no valid/ready handshake.
interface tone_envelope_if;
  logic       tone_in;
  logic       note_on;
  logic [3:0] note_code;
  logic       pwm_out;
  logic [7:0] env_level;
  logic [2:0] env_state;
  logic       busy;

  modport master (
    output tone_in, note_on, note_code,
    input  pwm_out, env_level, env_state, busy
  );

  modport slave (
    input  tone_in, note_on, note_code,
    output pwm_out, env_level, env_state, busy
  );
endinterface

// File: rtl/tone_envelope.sv
// ADSR amplitude shaper: gates the raw tone with an 8-bit PWM whose duty follows the envelope.
// Optional feature macro: ENV_RETRIGGER_EN (a note change while held restarts ATTACK).
module tone_envelope #(
  parameter logic [15:0] ATTACK_DIV    = 16'd64,
  parameter logic [15:0] DECAY_DIV     = 16'd128,
  parameter logic [15:0] RELEASE_DIV   = 16'd256,
  parameter logic [7:0]  SUSTAIN_LEVEL = 8'd160
) (
  input logic           clk,
  input logic           rst_n,
  tone_envelope_if.slave env_if
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_e;

  env_state_e  state_q;
  logic [7:0]  level_q;
  logic [15:0] presc_q;
  logic [7:0]  pwm_cnt_q;
  logic        pwm_q;

  logic        note_on;
  logic        tone_in;
  logic [15:0] div_cur;
  logic        tick;
  logic        retrig;
  logic [7:0]  level_inc;
  logic [7:0]  level_dec;

  assign note_on = env_if.note_on;
  assign tone_in = env_if.tone_in;

  always_comb begin
    div_cur = RELEASE_DIV;
    case (state_q)
      ST_ATTACK: div_cur = ATTACK_DIV;
      ST_DECAY:  div_cur = DECAY_DIV;
      default:   div_cur = RELEASE_DIV;
    endcase
  end

  // Only the three ramping phases ever produce step ticks.
  assign tick = ((state_q == ST_ATTACK) || (state_q == ST_DECAY) || (state_q == ST_RELEASE))
                && (presc_q == (div_cur - 16'd1));

  assign level_inc = (level_q == 8'hFF) ? 8'hFF : (level_q + 8'd1);
  assign level_dec = (level_q == 8'h00) ? 8'h00 : (level_q - 8'd1);

`ifdef ENV_RETRIGGER_EN
  logic [3:0] code_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_q <= 4'd0;
    end else begin
      code_q <= env_if.note_code;
    end
  end

  assign retrig = note_on && (env_if.note_code != code_q);
`else
  logic unused_note_code;

  assign unused_note_code = ^env_if.note_code;
  assign retrig           = 1'b0;
`endif

  // Every branch that changes state also clears the prescaler.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      level_q <= 8'd0;
      presc_q <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          presc_q <= 16'd0;
          if (note_on) begin
            state_q <= ST_ATTACK;
          end
        end

        ST_ATTACK: begin
          if (!note_on) begin
            state_q <= ST_RELEASE;
            presc_q <= 16'd0;
          end else if (level_q == 8'hFF) begin
            state_q <= ST_DECAY;
            presc_q <= 16'd0;
          end else if (tick) begin
            level_q <= level_inc;
            presc_q <= 16'd0;
            if (level_inc == 8'hFF) begin
              state_q <= ST_DECAY;
            end
          end else begin
            presc_q <= presc_q + 16'd1;
          end
        end

        ST_DECAY: begin
          if (!note_on) begin
            state_q <= ST_RELEASE;
            presc_q <= 16'd0;
          end else if (retrig) begin
            state_q <= ST_ATTACK;
            presc_q <= 16'd0;
          end else if (level_q <= SUSTAIN_LEVEL) begin
            state_q <= ST_SUSTAIN;
            level_q <= SUSTAIN_LEVEL;
            presc_q <= 16'd0;
          end else if (tick) begin
            level_q <= level_dec;
            presc_q <= 16'd0;
            if (level_dec <= SUSTAIN_LEVEL) begin
              state_q <= ST_SUSTAIN;
              level_q <= SUSTAIN_LEVEL;
            end
          end else begin
            presc_q <= presc_q + 16'd1;
          end
        end

        ST_SUSTAIN: begin
          level_q <= SUSTAIN_LEVEL;
          presc_q <= 16'd0;
          if (!note_on) begin
            state_q <= ST_RELEASE;
          end else if (retrig) begin
            state_q <= ST_ATTACK;
          end
        end

        ST_RELEASE: begin
          if (note_on) begin
            state_q <= ST_ATTACK;
            presc_q <= 16'd0;
          end else if (level_q == 8'h00) begin
            state_q <= ST_IDLE;
            presc_q <= 16'd0;
          end else if (tick) begin
            level_q <= level_dec;
            presc_q <= 16'd0;
            if (level_dec == 8'h00) begin
              state_q <= ST_IDLE;
            end
          end else begin
            presc_q <= presc_q + 16'd1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          level_q <= 8'd0;
          presc_q <= 16'd0;
        end
      endcase
    end
  end

  // Free-running PWM carrier; level 255 still leaves one low slot per period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt_q <= 8'd0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      pwm_q     <= tone_in & (pwm_cnt_q < level_q);
    end
  end

  assign env_if.pwm_out   = pwm_q;
  assign env_if.env_level = level_q;
  assign env_if.env_state = state_q;
  assign env_if.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tone_envelope.sv
// Randomized scoreboard bench for tone_envelope against a phase/level reference model.
`timescale 1ns/1ps
module tb_tone_envelope;

  localparam logic [15:0] A_DIV = 16'd1;
  localparam logic [15:0] D_DIV = 16'd2;
  localparam logic [15:0] R_DIV = 16'd4;
  localparam logic [7:0]  S_LVL = 8'd128;
  localparam int W = 13;

  localparam int P_IDLE = 0;
  localparam int P_ATK  = 1;
  localparam int P_DEC  = 2;
  localparam int P_SUS  = 3;
  localparam int P_REL  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tone_envelope_if env_if ();

  tone_envelope #(
    .ATTACK_DIV   (A_DIV),
    .DECAY_DIV    (D_DIV),
    .RELEASE_DIV  (R_DIV),
    .SUSTAIN_LEVEL(S_LVL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .env_if(env_if)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit duty_win = 1'b0;
  int duty_hi  = 0;
  logic [W-1:0] mon_e;
  logic [W-1:0] mon_a;

  // ---------------- reference model ----------------
  int          m_phase = P_IDLE;
  int          m_level = 0;
  int          m_win   = 0;   // cycles elapsed in the current step window
  int unsigned m_cycle = 0;   // cycles since reset, drives the PWM slot
  int          m_code  = 0;
  logic [3:0]  cur_code = 4'd0;

  task automatic model_edge(input bit rst, input bit on, input bit tone, input int code,
                            output logic [W-1:0] e);
    int div;
    int nxt;
    int nlvl;
    bit step;
    bit retrig;
    bit pwm;
    pwm = 1'b0;
    if (rst) begin
      m_phase = P_IDLE;
      m_level = 0;
      m_win   = 0;
      m_cycle = 0;
      m_code  = 0;
    end else begin
      pwm = tone && (int'(m_cycle % 256) < m_level);
      m_cycle++;
      div  = (m_phase == P_ATK) ? int'(A_DIV) : (m_phase == P_DEC) ? int'(D_DIV) : int'(R_DIV);
      step = (m_phase == P_ATK || m_phase == P_DEC || m_phase == P_REL) && (m_win + 1 >= div);
`ifdef ENV_RETRIGGER_EN
      retrig = on && (code != m_code) && (m_phase == P_DEC || m_phase == P_SUS);
`else
      retrig = 1'b0;
`endif
      m_code = code;
      nxt  = m_phase;
      nlvl = m_level;
      case (m_phase)
        P_IDLE: if (on) nxt = P_ATK;
        P_ATK: begin
          if (!on) nxt = P_REL;
          else if (m_level >= 255) nxt = P_DEC;
          else if (step) begin
            nlvl = (m_level + 1 > 255) ? 255 : m_level + 1;
            if (nlvl == 255) nxt = P_DEC;
          end
        end
        P_DEC: begin
          if (!on) nxt = P_REL;
          else if (retrig) nxt = P_ATK;
          else if (m_level <= int'(S_LVL)) begin
            nxt = P_SUS;
            nlvl = int'(S_LVL);
          end else if (step) begin
            nlvl = (m_level - 1 < 0) ? 0 : m_level - 1;
            if (nlvl <= int'(S_LVL)) begin
              nxt = P_SUS;
              nlvl = int'(S_LVL);
            end
          end
        end
        P_SUS: begin
          nlvl = int'(S_LVL);
          if (!on) nxt = P_REL;
          else if (retrig) nxt = P_ATK;
        end
        default: begin
          if (on) nxt = P_ATK;
          else if (m_level == 0) nxt = P_IDLE;
          else if (step) begin
            nlvl = (m_level - 1 < 0) ? 0 : m_level - 1;
            if (nlvl == 0) nxt = P_IDLE;
          end
        end
      endcase
      if (nxt != m_phase || step) m_win = 0;
      else m_win++;
      m_phase = nxt;
      m_level = nlvl;
    end
    e = {3'(m_phase), 8'(m_level), pwm, (m_phase != P_IDLE)};
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit rst, input bit on, input bit tone, input logic [3:0] code);
    logic [W-1:0] e;
    rst_n            = !rst;
    env_if.note_on   = on;
    env_if.tone_in   = tone;
    env_if.note_code = code;
    model_edge(rst, on, tone, int'(code), e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit on, input int tone_mode);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, on, (tone_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(tone_mode), cur_code);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {env_if.env_state, env_if.env_level, env_if.pwm_out, env_if.busy};
      n_vec++;
      if (mon_a !== mon_e) begin
        n_err++;
        $display("FAIL cyc%0d state/level/pwm/busy got %0d/%0d/%0b/%0b exp %0d/%0d/%0b/%0b",
                 cyc, mon_a[12:10], mon_a[9:2], mon_a[1], mon_a[0],
                 mon_e[12:10], mon_e[9:2], mon_e[1], mon_e[0]);
      end
      if (duty_win && env_if.pwm_out === 1'b1) duty_hi++;
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    // Reset with key held and tone high: everything stays zero.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1, 4'd0);

    // Full attack to 255, decay to sustain, then hold.
    run(1 + 255 + 254 + 20, 1'b1, 2);

    // Duty in sustain: 128 high slots per 256 cycles with tone held high.
    run(8, 1'b1, 1);
    duty_hi  = 0;
    duty_win = 1'b1;
    run(256, 1'b1, 1);
    duty_win = 1'b0;
    n_vec++;
    if (duty_hi != int'(S_LVL)) begin
      n_err++;
      $display("FAIL sustain_duty high_slots got %0d exp %0d", duty_hi, S_LVL);
    end
    run(20, 1'b1, 0);

    // Release all the way down to idle.
    run(520, 1'b0, 2);

    // Re-attack out of release at level 60, then drop during attack.
    run(80, 1'b1, 2);
    guard = 0;
    while (m_level != 60 && guard < 1000) begin
      run(1, 1'b0, 2);
      guard++;
    end
    run(10, 1'b1, 2);
    run(30, 1'b0, 2);
    run(300, 1'b0, 2);

    // Note change while held in sustain.
    cur_code = 4'd3;
    run(600, 1'b1, 2);
    cur_code = 4'd7;
    run(20, 1'b1, 2);
    run(1100, 1'b0, 2);

    // Reset in the middle of a note.
    run(100, 1'b1, 2);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, cur_code);
    run(20, 1'b1, 2);

    // Random segments.
    for (int s = 0; s < 40; s++) begin
      bit on;
      int len;
      on  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 400);
      if ($urandom_range(0, 9) == 0) begin
        drive(1'b1, on, 1'b1, cur_code);
        drive(1'b1, on, 1'b0, cur_code);
      end
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 31) == 0) cur_code = 4'($urandom_range(0, 15));
        run(1, on, 2);
      end
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending got %0d exp 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
